// File: rtl/rf_pkg.sv
// Shared constants for the 8-entry register file read port.
package rf_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    localparam logic [ADDR_W-1:0] REG0 = 3'd0;
    localparam logic [ADDR_W-1:0] REG1 = 3'd1;
    localparam logic [ADDR_W-1:0] REG2 = 3'd2;
    localparam logic [ADDR_W-1:0] REG3 = 3'd3;
    localparam logic [ADDR_W-1:0] REG4 = 3'd4;
    localparam logic [ADDR_W-1:0] REG5 = 3'd5;
    localparam logic [ADDR_W-1:0] REG6 = 3'd6;
    localparam logic [ADDR_W-1:0] REG7 = 3'd7;
endpackage

// File: rtl/mux8_dw.sv
// 8:1 combinational multiplexer built as a tree of 2:1 stages (sel[0], then sel[1], then sel[2]).
module mux8_dw
    import rf_pkg::*;
#(
    parameter int DATA_W = rf_pkg::DATA_W
) (
    input  logic [ADDR_W-1:0]             sel_i,
    input  logic [NUM_REGS-1:0][DATA_W-1:0] d_i,
    output logic [DATA_W-1:0]             y_o
);

    // An unknown select yields all-X rather than letting a ternary merge equal bits.
    function automatic logic [DATA_W-1:0] mux2(
        input logic              s,
        input logic [DATA_W-1:0] a0,
        input logic [DATA_W-1:0] a1
    );
        case (s)
            1'b0:    mux2 = a0;
            1'b1:    mux2 = a1;
            default: mux2 = 'x;
        endcase
    endfunction

    logic [3:0][DATA_W-1:0] lvl1;
    logic [1:0][DATA_W-1:0] lvl2;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lvl1[i] = mux2(sel_i[0], d_i[2*i], d_i[2*i+1]);
        end
        for (int j = 0; j < 2; j++) begin
            lvl2[j] = mux2(sel_i[1], lvl1[2*j], lvl1[2*j+1]);
        end
        y_o = mux2(sel_i[2], lvl2[0], lvl2[1]);
    end

endmodule

// File: rtl/read_operation.sv
// Register file read port: zero-latency mux output plus a one-cycle registered copy with valid flag.
module read_operation
    import rf_pkg::*;
#(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] from_reg0,
    input  logic [DATA_W-1:0] from_reg1,
    input  logic [DATA_W-1:0] from_reg2,
    input  logic [DATA_W-1:0] from_reg3,
    input  logic [DATA_W-1:0] from_reg4,
    input  logic [DATA_W-1:0] from_reg5,
    input  logic [DATA_W-1:0] from_reg6,
    input  logic [DATA_W-1:0] from_reg7,
    output logic [DATA_W-1:0] Data,
    output logic [DATA_W-1:0] Data_q,
    output logic              Data_q_valid
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [DATA_W-1:0]               data_q_q;
    logic [DATA_W-1:0]               data_q_d;
    logic                            valid_q;
    logic                            valid_d;

    assign regs = {from_reg7, from_reg6, from_reg5, from_reg4,
                   from_reg3, from_reg2, from_reg1, from_reg0};

    mux8_dw #(
        .DATA_W(DATA_W)
    ) u_mux (
        .sel_i(Addr),
        .d_i  (regs),
        .y_o  (Data)
    );

    always_comb begin
        data_q_d = Data;
        valid_d  = 1'b1;
    end

    // Reset clears only the registered copy; Data keeps working during reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            data_q_q <= data_q_d;
            valid_q  <= valid_d;
        end
    end

    assign Data_q       = data_q_q;
    assign Data_q_valid = valid_q;

endmodule

// File: tb/tb_read_operation.sv
// Self-checking bench for read_operation: directed scenarios plus randomized traffic against a behavioural model.
module tb_read_operation;

    logic        clk;
    logic        reset_n;
    logic [2:0]  addr;
    logic [31:0] rv [8];
    logic [31:0] data;
    logic [31:0] data_q;
    logic        data_q_valid;

    int total = 0;
    int bad   = 0;

    read_operation dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .Addr        (addr),
        .from_reg0   (rv[0]),
        .from_reg1   (rv[1]),
        .from_reg2   (rv[2]),
        .from_reg3   (rv[3]),
        .from_reg4   (rv[4]),
        .from_reg5   (rv[5]),
        .from_reg6   (rv[6]),
        .from_reg7   (rv[7]),
        .Data        (data),
        .Data_q      (data_q),
        .Data_q_valid(data_q_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_table();
        rv[0] = 32'hffffffff; rv[1] = 32'h11111111;
        rv[2] = 32'h12345678; rv[3] = 32'h13579bdf;
        rv[4] = 32'habcd1234; rv[5] = 32'hef126793;
        rv[6] = 32'h98765432; rv[7] = 32'h2468acde;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        addr    = 3'd0;
        for (int i = 0; i < 8; i++) rv[i] = 32'h0;
        #3;
        total++;
        if (data !== 32'h0) begin
            bad++; $display("FAIL reset_data: got %h want %h", data, 32'h0);
        end
        total++;
        if (data_q !== 32'h0 || data_q_valid !== 1'b0) begin
            bad++; $display("FAIL reset_regs: got %h/%b want 0/0", data_q, data_q_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (data_q !== 32'h0 || data_q_valid !== 1'b0) begin
            bad++; $display("FAIL reset_held: got %h/%b want 0/0", data_q, data_q_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++;
        if (data_q_valid !== 1'b0) begin
            bad++; $display("FAIL release_no_edge: valid got %b want 0", data_q_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (data_q !== 32'h0 || data_q_valid !== 1'b1) begin
            bad++; $display("FAIL first_edge: got %h/%b want 0/1", data_q, data_q_valid);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] exp_tab [8];
        exp_tab = '{32'hffffffff, 32'h11111111, 32'h12345678, 32'h13579bdf,
                    32'habcd1234, 32'hef126793, 32'h98765432, 32'h2468acde};
        load_table();
        for (int i = 0; i < 8; i++) begin
            addr = 3'(i);
            #1;
            total++;
            if (data !== exp_tab[i]) begin
                bad++; $display("FAIL sweep addr=%0d: got %h want %h", i, data, exp_tab[i]);
            end
            #9;
        end
    endtask

    task automatic test_select_tracking();
        addr  = 3'b101;
        rv[5] = 32'h00000000;
        #1;
        total++;
        if (data !== 32'h0) begin
            bad++; $display("FAIL selected_change: got %h want %h", data, 32'h0);
        end
        rv[4] = 32'h5a5a0f0f;
        #1;
        total++;
        if (data !== 32'h0) begin
            bad++; $display("FAIL unselected_change: got %h want %h", data, 32'h0);
        end
        load_table();
    endtask

    task automatic test_pipeline();
        @(negedge clk);
        addr = 3'd2;
        @(posedge clk);
        #1;
        total++;
        if (data_q !== 32'h12345678 || data_q_valid !== 1'b1) begin
            bad++; $display("FAIL pipe_a2: got %h/%b want 12345678/1", data_q, data_q_valid);
        end
        @(negedge clk);
        addr = 3'd3;
        #1;
        total++;
        if (data !== 32'h13579bdf || data_q !== 32'h12345678) begin
            bad++; $display("FAIL pipe_latency: got data %h q %h want 13579bdf/12345678", data, data_q);
        end
        @(posedge clk);
        #1;
        total++;
        if (data_q !== 32'h13579bdf) begin
            bad++; $display("FAIL pipe_a3: got %h want 13579bdf", data_q);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        addr = 3'd7;
        @(posedge clk);
        #1;
        total++;
        if (data_q !== 32'h2468acde) begin
            bad++; $display("FAIL pre_reset_q: got %h want 2468acde", data_q);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (data_q !== 32'h0 || data_q_valid !== 1'b0) begin
            bad++; $display("FAIL async_clear: got %h/%b want 0/0", data_q, data_q_valid);
        end
        total++;
        if (data !== 32'h2468acde) begin
            bad++; $display("FAIL data_in_reset: got %h want 2468acde", data);
        end
        @(posedge clk);
        #1;
        total++;
        if (data_q !== 32'h0 || data_q_valid !== 1'b0) begin
            bad++; $display("FAIL reset_beats_edge: got %h/%b want 0/0", data_q, data_q_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (data_q !== 32'h2468acde || data_q_valid !== 1'b1) begin
            bad++; $display("FAIL re_release: got %h/%b want 2468acde/1", data_q, data_q_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_d;
        logic [31:0] exp_q;
        logic        exp_v;
        bit          do_rst;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) rv[i] = $urandom;
            addr    = 3'($urandom_range(7));
            exp_d   = rv[addr];
            do_rst  = ($urandom_range(15) == 0);
            reset_n = !do_rst;
            #1;
            total++;
            if (data !== exp_d) begin
                bad++; $display("FAIL rand_data k=%0d: got %h want %h", k, data, exp_d);
            end
            exp_q = do_rst ? 32'h0 : exp_d;
            exp_v = !do_rst;
            @(posedge clk);
            #1;
            total++;
            if (data_q !== exp_q || data_q_valid !== exp_v) begin
                bad++; $display("FAIL rand_q k=%0d: got %h/%b want %h/%b", k, data_q, data_q_valid, exp_q, exp_v);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        load_table();
    endtask

    task automatic test_x_addr();
        addr = 3'bx1x;
        #1;
        if ($isunknown(addr)) begin
            total++;
            if (data !== 32'hxxxxxxxx) begin
                bad++; $display("FAIL x_addr: got %h want all-x", data);
            end
        end
        addr = 3'b111;
        #1;
        total++;
        if (data !== 32'h2468acde) begin
            bad++; $display("FAIL x_restore: got %h want 2468acde", data);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_select_tracking();
        test_pipeline();
        test_async_reset();
        test_random();
        test_x_addr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
